// File: rtl/fifo_salida.sv
// Output-side FIFO for one destination port of the transaction layer.
// Stores arbiter pushes in order and exposes count-decoded occupancy flags plus sticky error flags.
module fifo_salida #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int FIFO_DEPTH     = 8,
  parameter int ADDR_SIZE      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [FIFO_WORD_SIZE-1:0] data_in,
  input  logic                      pop,
  input  logic [ADDR_SIZE:0]        umbral_alto,
  input  logic [ADDR_SIZE:0]        umbral_bajo,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      valid_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      err_overflow,
  output logic                      err_underflow
);

  localparam logic [ADDR_SIZE:0]   DEPTH_C = (ADDR_SIZE+1)'(FIFO_DEPTH);
  localparam logic [ADDR_SIZE:0]   CNT_ONE = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

  logic [FIFO_WORD_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic [ADDR_SIZE-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]        count_q, count_d;
  logic [FIFO_WORD_SIZE-1:0] data_out_q, data_out_d;
  logic                      valid_q, valid_d;
  logic                      err_ovf_q, err_ovf_d;
  logic                      err_unf_q, err_unf_d;

  logic full_w, empty_w, wr_acc, rd_acc;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  always_comb begin
    wr_acc     = push && (!full_w || pop);
    rd_acc     = pop && !empty_w;
    wr_ptr_d   = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    data_out_d = rd_acc ? mem_q[rd_ptr_q] : data_out_q;
    valid_d    = rd_acc;
    // A pop on a full FIFO frees the slot, so only an unpaired push overflows.
    err_ovf_d  = err_ovf_q | (push && full_w && !pop);
    err_unf_d  = err_unf_q | (pop && empty_w);
  end

  // ---- state register stage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
    end
  end

  // Storage is not cleared on reset; only writes on a reset edge are suppressed.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out      = data_out_q;
  assign valid_out     = valid_q;
  assign empty         = empty_w;
  assign full          = full_w;
  assign almost_full   = (count_q >= umbral_alto);
  assign almost_empty  = (count_q <= umbral_bajo);
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_fifo_salida.sv
// Directed bench for fifo_salida: a queue-based reference checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fifo_salida;

  localparam int W = 10;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         reset, push, pop;
  logic [W-1:0] data_in;
  logic [A:0]   umbral_alto, umbral_bajo;
  logic [W-1:0] data_out;
  logic         valid_out, empty, full, almost_full, almost_empty;
  logic         err_overflow, err_underflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  fifo_salida #(.FIFO_WORD_SIZE(W), .FIFO_DEPTH(D), .ADDR_SIZE(A)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue semantics.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  bit           m_vld, m_ovf, m_unf;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      if (pop && !was_empty) begin
        m_dout = q.pop_front();
        m_vld  = 1'b1;
      end else begin
        m_vld  = 1'b0;
      end
      if (push && (!was_full || pop)) q.push_back(data_in);
      if (push && was_full && !pop) m_ovf = 1'b1;
      if (pop && was_empty) m_unf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_data_out", data_out, m_dout);
      chk("m_valid_out", valid_out, m_vld);
      chk("m_empty", empty, q.size() == 0);
      chk("m_full", full, q.size() == D);
      chk("m_almost_full", almost_full, q.size() >= int'(umbral_alto));
      chk("m_almost_empty", almost_empty, q.size() <= int'(umbral_bajo));
      chk("m_err_overflow", err_overflow, m_ovf);
      chk("m_err_underflow", err_underflow, m_unf);
    end
  end

  // Apply one cycle of inputs, then return just after the edge with inputs idle.
  task automatic cyc(input logic r, input logic p, input logic [W-1:0] d, input logic po);
    reset = r; push = p; data_in = d; pop = po;
    @(posedge clk);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_alto = 4'd6; umbral_bajo = 4'd1;

    // Reset then idle
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_errs", {err_overflow, err_underflow}, 0);

    // Fill and drain
    for (int i = 1; i <= D; i++) begin
      cyc(1'b0, 1'b1, W'(i), 1'b0);
      if (i == 1) chk("fill1_almost_empty", almost_empty, 1);
      if (i == 2) chk("fill2_almost_empty", almost_empty, 0);
      if (i == 5) chk("fill5_almost_full", almost_full, 0);
      if (i == 6) chk("fill6_almost_full", almost_full, 1);
      if (i == 7) chk("fill7_full", full, 0);
    end
    chk("fill8_full", full, 1);
    for (int i = 1; i <= D; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      chk("drain_data", data_out, i);
      chk("drain_valid", valid_out, 1);
    end
    chk("drain_empty", empty, 1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("idle_valid", valid_out, 0);
    chk("idle_hold", data_out, 8);

    // Wrap-around
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, W'(10'h010 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      chk("wrap5_data", data_out, 32'h010 + i);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, W'(10'h020 + i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      chk("wrap8_data", data_out, 32'h020 + i);
    end
    chk("wrap_errs", {err_overflow, err_underflow}, 0);

    // Simultaneous push and pop while full
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, W'(10'h100 + i), 1'b0);
    cyc(1'b0, 1'b1, 10'h3FF, 1'b1);
    chk("fullpp_data", data_out, 32'h101);
    chk("fullpp_full", full, 1);
    chk("fullpp_ovf", err_overflow, 0);
    for (int i = 2; i <= 8; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      chk("fullpp_drain", data_out, 32'h100 + i);
    end
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("fullpp_last", data_out, 32'h3FF);
    chk("fullpp_empty", empty, 1);

    // Overflow keeps contents, underflow on empty pop
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, W'(10'h0A0 + i), 1'b0);
    cyc(1'b0, 1'b1, 10'h2AA, 1'b0);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_full", full, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      chk("ovf_contents", data_out, 32'h0A0 + i);
    end
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("unf_flag", err_underflow, 1);
    chk("unf_valid", valid_out, 0);
    chk("unf_hold", data_out, 32'h0A8);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("sticky_errs", {err_overflow, err_underflow}, 2'b11);

    // Push and pop while empty: only the write lands
    cyc(1'b0, 1'b1, 10'h155, 1'b1);
    chk("emptypp_valid", valid_out, 0);
    chk("emptypp_empty", empty, 0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("emptypp_data", data_out, 32'h155);

    // Threshold extremes follow immediately
    umbral_alto = 4'd0; umbral_bajo = 4'd8;
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("thr_af_zero", almost_full, 1);
    chk("thr_ae_depth", almost_empty, 1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, W'(10'h040 + i), 1'b0);
    chk("thr_ae_full", almost_empty, 1);
    umbral_alto = 4'd8; umbral_bajo = 4'd7;
    #1;
    chk("thr_af_8", almost_full, 1);
    chk("thr_ae_7", almost_empty, 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    umbral_alto = 4'd6; umbral_bajo = 4'd1;

    // Reset in the middle of traffic, with a push on the reset edge
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, W'(10'h060 + i), 1'b0);
    cyc(1'b1, 1'b1, 10'h0CC, 1'b0);
    chk("midrst_empty", empty, 1);
    chk("midrst_data", data_out, 0);
    chk("midrst_errs", {err_overflow, err_underflow}, 0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("midrst_unf", err_underflow, 1);
    chk("midrst_valid", valid_out, 0);
    chk("midrst_still_empty", empty, 1);

    // Reset with almost-full threshold at zero
    umbral_alto = 4'd0;
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("rst_af_zero", almost_full, 1);
    cyc(1'b0, 1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_salida.md
# fifo_salida

Output-side FIFO of the transaction layer: one instance per destination port, sitting directly downstream of the 4-port arbiter. It stores the words the arbiter pushes into that port, reports occupancy (empty, full, programmable almost-full/almost-empty) back to the arbiter and to the consumer, and delivers words in order on pop. The almost_full output feeds the arbiter's back-pressure input for that port.

## Interface

Parameters:
- FIFO_WORD_SIZE, 10, word width; bits [FIFO_WORD_SIZE-1:FIFO_WORD_SIZE-2] are the destination field and are stored unmodified.
- FIFO_DEPTH, 8, number of entries; power of two, at least 4.
- ADDR_SIZE, 3, log2(FIFO_DEPTH); pointer width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- push  input  1  write request; word on data_in is written on the same edge.
- data_in  input  FIFO_WORD_SIZE  word to write.
- pop  input  1  read request.
- umbral_alto  input  ADDR_SIZE+1  almost-full threshold, 0..FIFO_DEPTH.
- umbral_bajo  input  ADDR_SIZE+1  almost-empty threshold, 0..FIFO_DEPTH.
- data_out  output  FIFO_WORD_SIZE  registered read data.
- valid_out  output  1  high for one cycle when data_out carries a newly popped word.
- empty  output  1  count == 0.
- full  output  1  count == FIFO_DEPTH.
- almost_full  output  1  count >= umbral_alto.
- almost_empty  output  1  count <= umbral_bajo.
- err_overflow  output  1  sticky: push while full without accepted pop.
- err_underflow  output  1  sticky: pop while empty.

## Operation

- State: memory of FIFO_DEPTH words, wr_ptr and rd_ptr (ADDR_SIZE bits, wrap modulo FIFO_DEPTH), count (ADDR_SIZE+1 bits, 0..FIFO_DEPTH).
- Accepted write: push && (!full || pop). Writes mem[wr_ptr], wr_ptr+1.
- Accepted read: pop && !empty. data_out <= mem[rd_ptr], rd_ptr+1, valid_out <= 1; otherwise valid_out <= 0 and data_out holds its value.
- count next = count + write_acc - read_acc; never leaves 0..FIFO_DEPTH.
- Full with push and pop: both accepted, count unchanged, popped word is the oldest, never the word being written.
- Empty with push and pop: write accepted, read rejected, err_underflow set; word is readable from the next cycle.
- Full with push, no pop: write dropped, memory and pointers unchanged, err_overflow set.
- Pop on empty with no push: no state change except err_underflow set.
- Flags are decodes of the count register (no combinational path from push/pop/data_in to any output).
- umbral_alto = 0 forces almost_full high; umbral_bajo >= FIFO_DEPTH forces almost_empty high. Thresholds may change any cycle; flags follow on the same cycle.
- Error flags clear only on reset.

## Timing

- Reset (any cycle, including mid-transfer): wr_ptr, rd_ptr, count = 0; data_out = 0; valid_out = 0; empty = 1; full = 0; err_overflow = err_underflow = 0; almost_empty = 1; almost_full = (umbral_alto == 0). Push/pop on a reset edge are ignored; memory contents are not cleared.
- Write latency: word pushed at edge N is poppable at edge N+1; empty deasserts after edge N.
- Read latency: pop at edge N -> data_out/valid_out valid after edge N, i.e. during cycle N+1.
- Flags update in the cycle following the edge that changes count.
- Back-pressure: arbiter must stop pushing the cycle after almost_full rises; with umbral_alto = FIFO_DEPTH-2 there are two entries of slack for in-flight registered pushes.
- Throughput: one push and one pop per cycle, sustained.

## Test plan

- Reset then idle: after reset high one edge -> empty=1, full=0, almost_empty=1, data_out=0, valid_out=0, errors 0.
- Fill/drain, DEPTH=8, umbral_alto=6, umbral_bajo=1: push 0x001..0x008 -> almost_full rises after 6th push, full after 8th; pop 8 -> data_out 0x001..0x008 in order, valid_out high each cycle, empty after last.
- Wrap-around: push 5, pop 5, push 8, pop 8 -> order preserved across pointer wrap, no errors.
- Simultaneous full push+pop: full with 0x101..0x108, push 0x3FF with pop -> data_out 0x101, count stays 8, 0x3FF read last.
- Errors: push 0x2AA while full -> err_overflow=1, contents unchanged; pop on empty -> err_underflow=1, valid_out=0; both stay high until reset.
- Reset mid-operation: 4 words stored, reset with push=1 -> count 0, empty=1, next pop gives underflow, pushed word not stored.
